axi_lite_sram_slave: RTL
========================

# axi_lite_sram_slave

AXI4-Lite responder that backs the SRAM-side AXI-Lite master with a parameterised on-chip word memory. It accepts independent write (AW/W/B) and read (AR/R) transactions, applies byte strobes, and inserts a programmable access latency so the master's handshake logic is exercised under realistic delays. It sits directly on the master's AXI-Lite port in simulation and in the SoC memory path.

## Interface
- ADDR_WIDTH, 64, address width
- DATA_WIDTH, 64, data width; byte lanes NB = DATA_WIDTH/8
- DEPTH, 1024, memory words (power of two)
- BASE_ADDR, 64'h8000_0000, byte address of word 0
- RD_LAT, 1, cycles from AR handshake to R_VALID (≥1)
- WR_LAT, 1, cycles from write-capture complete to B_VALID (≥1)

Ports:
- CLK  in  1  clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- AW_ADDR  in  ADDR_WIDTH  write address
- AW_VALID  in  1 / AW_READY  out  1  write-address handshake
- W_DATA  in  DATA_WIDTH / W_STRB  in  NB  write data and byte strobes
- W_VALID  in  1 / W_READY  out  1  write-data handshake
- B_RESP  out  2 / B_VALID  out  1 / B_READY  in  1  write response
- AR_ADDR  in  ADDR_WIDTH / AR_VALID  in  1 / AR_READY  out  1  read address
- R_DATA  out  DATA_WIDTH / R_RESP  out  2 / R_VALID  out  1 / R_READY  in  1  read data

## Operation
- Index = (ADDR − BASE_ADDR) >> log2(NB); low log2(NB) bits ignored. In range iff BASE_ADDR ≤ ADDR < BASE_ADDR + DEPTH·NB.
- Write FSM: W_IDLE → W_BUSY → W_RESP → W_IDLE.
  - In W_IDLE, AW and W accepted independently, any order or same cycle; each captured once (AW_READY drops after AW captured, W_READY after W captured).
  - Both captured → W_BUSY, latency counter loaded; AW_READY = W_READY = 0 in W_BUSY and W_RESP.
  - Counter expiry: commit write (lanes with W_STRB[i]=1 only), raise B_VALID, enter W_RESP.
  - W_RESP: B_VALID held, B_RESP stable until B_VALID && B_READY; then W_IDLE, capture flags cleared.
- Read FSM: R_IDLE → R_BUSY → R_RESP → R_IDLE.
  - AR_READY = 1 only in R_IDLE; handshake captures address.
  - Counter expiry: sample memory into R_DATA, raise R_VALID.
  - R_DATA/R_RESP stable while R_VALID && !R_READY; handshake returns to R_IDLE.
- Responses: in range → 2'b00 OKAY; out of range → 2'b10 SLVERR, write discarded, R_DATA = 0.
- Read and write paths fully independent; at most one outstanding of each.
- Same-word collision: read sample and write commit on same edge → read returns pre-write data.
- Memory contents are not reset.

## Timing
- While RESET=1 and the first edge after: all outputs 0, both FSMs idle, counters 0, capture flags cleared; AW_READY/W_READY/AR_READY rise the cycle after RESET falls.
- Reset mid-transaction: outstanding read/write dropped, no B/R response issued; an uncommitted write is never committed.
- Write: last of AW/W handshakes in cycle t → memory commit and B_VALID=1 in cycle t+WR_LAT.
- Read: AR handshake in cycle t → R_VALID=1 with valid R_DATA in cycle t+RD_LAT.
- Zero-bubble return: response handshake in cycle t → READY(s) high in cycle t+1; next address accepted no earlier than t+1.
- READY outputs depend only on state, never combinationally on VALID inputs.
- Counter width ≥ clog2(max(RD_LAT,WR_LAT)+1); no wrap.

## Test plan
- AW+W same cycle, addr 0x8000_0010, data 0x1122_3344_5566_7788, strobe 0xFF; then read same addr → B_RESP=00 at t+WR_LAT, R_DATA=0x1122_3344_5566_7788, R_RESP=00 at t+RD_LAT.
- W three cycles before AW, strobe 0x0F, data 0xAAAA_AAAA_BBBB_BBBB over prior 0x1122_3344_5566_7788 → readback 0x1122_3344_BBBB_BBBB; W_READY low after W capture until B handshake.
- Write and read to 0x0000_1000 (out of range) → B_RESP=10, R_RESP=10, R_DATA=0, memory unchanged.
- B_READY and R_READY held low 3 cycles → B_VALID/R_VALID and payloads stable all 3 cycles, AW/W/AR_READY stay 0, single handshake each.
- RESET pulsed in cycle after AR handshake with RD_LAT=4 → no R_VALID ever for that read, AR_READY=1 one cycle after RESET drops; prior memory contents intact.
- RD_LAT=3, WR_LAT=2, concurrent read and write to same word, read sample coinciding with write commit → read returns old data; next read returns new.

Source files
------------

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite responder backed by an on-chip word memory.
// Independent read/write paths with programmable access latency.
module axi_lite_sram_slave #(
   parameter int                    ADDR_WIDTH = 64,
   parameter int                    DATA_WIDTH = 64,
   parameter int                    DEPTH      = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h8000_0000,
   parameter int                    RD_LAT     = 1,
   parameter int                    WR_LAT     = 1
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [ADDR_WIDTH-1:0]   i_aw_addr,
   input  logic                    i_aw_valid,
   output logic                    o_aw_ready,
   input  logic [DATA_WIDTH-1:0]   i_w_data,
   input  logic [DATA_WIDTH/8-1:0] i_w_strb,
   input  logic                    i_w_valid,
   output logic                    o_w_ready,
   output logic [1:0]              o_b_resp,
   output logic                    o_b_valid,
   input  logic                    i_b_ready,
   input  logic [ADDR_WIDTH-1:0]   i_ar_addr,
   input  logic                    i_ar_valid,
   output logic                    o_ar_ready,
   output logic [DATA_WIDTH-1:0]   o_r_data,
   output logic [1:0]              o_r_resp,
   output logic                    o_r_valid,
   input  logic                    i_r_ready
);

   localparam int NB      = DATA_WIDTH / 8;
   localparam int OFFB    = $clog2(NB);
   localparam int IDX_W   = $clog2(DEPTH);
   localparam int MAXLAT  = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
   localparam int CW      = $clog2(MAXLAT + 1);
   localparam logic [ADDR_WIDTH-1:0] SPAN =
      ADDR_WIDTH'(DEPTH) * ADDR_WIDTH'(NB);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {W_IDLE, W_BUSY, W_RESP} wst_t;
   typedef enum logic [1:0] {R_IDLE, R_BUSY, R_RESP} rst_t;

   function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] off;
      off = a - BASE_ADDR;
      return (a >= BASE_ADDR) && (off < SPAN);
   endfunction

   function automatic logic [IDX_W-1:0] f_index(
      input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] off;
      off = (a - BASE_ADDR) >> OFFB;
      return IDX_W'(off);
   endfunction

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   wst_t                  r_wst;
   logic                  r_aw_got;
   logic                  r_w_got;
   logic [ADDR_WIDTH-1:0] r_aw_addr;
   logic [DATA_WIDTH-1:0] r_w_data;
   logic [NB-1:0]         r_w_strb;
   logic [CW-1:0]         r_wcnt;
   logic                  r_aw_ready;
   logic                  r_w_ready;
   logic                  r_b_valid;
   logic [1:0]            r_b_resp;

   rst_t                  r_rst;
   logic [ADDR_WIDTH-1:0] r_ar_addr;
   logic [CW-1:0]         r_rcnt;
   logic                  r_ar_ready;
   logic                  r_r_valid;
   logic [1:0]            r_r_resp;
   logic [DATA_WIDTH-1:0] r_r_data;

   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_both;
   logic                  w_wr_fire;
   logic                  w_commit;
   logic [ADDR_WIDTH-1:0] w_wa;
   logic [DATA_WIDTH-1:0] w_wd;
   logic [NB-1:0]         w_ws;
   logic                  w_wr_ok;
   logic [IDX_W-1:0]      w_widx;

   logic                  w_ar_hs;
   logic                  w_rd_fire;
   logic [ADDR_WIDTH-1:0] w_ra;
   logic                  w_rd_ok;
   logic [IDX_W-1:0]      w_ridx;

   assign w_aw_hs = r_aw_ready & i_aw_valid;
   assign w_w_hs  = r_w_ready & i_w_valid;
   assign w_both  = (r_aw_got | w_aw_hs) & (r_w_got | w_w_hs);

   // With a latency of one the commit happens on the capture edge itself,
   // so the payload is taken straight from the bus when not yet captured.
   assign w_wa    = r_aw_got ? r_aw_addr : i_aw_addr;
   assign w_wd    = r_w_got ? r_w_data : i_w_data;
   assign w_ws    = r_w_got ? r_w_strb : i_w_strb;
   assign w_wr_ok = f_in_range(w_wa);
   assign w_widx  = f_index(w_wa);

   assign w_wr_fire =
      ((r_wst == W_IDLE) & w_both & (WR_LAT == 1)) |
      ((r_wst == W_BUSY) & (r_wcnt == CNT_ONE));
   assign w_commit = w_wr_fire & w_wr_ok & ~i_reset;

   assign w_ar_hs   = r_ar_ready & i_ar_valid;
   assign w_ra      = (r_rst == R_IDLE) ? i_ar_addr : r_ar_addr;
   assign w_rd_ok   = f_in_range(w_ra);
   assign w_ridx    = f_index(w_ra);
   assign w_rd_fire =
      ((r_rst == R_IDLE) & w_ar_hs & (RD_LAT == 1)) |
      ((r_rst == R_BUSY) & (r_rcnt == CNT_ONE));

   always_ff @(posedge i_clk) begin
      if (w_commit) begin
         for (int i = 0; i < NB; i++) begin
            if (w_ws[i]) begin
               r_mem[w_widx][i*8 +: 8] <= w_wd[i*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wst      <= W_IDLE;
         r_aw_got   <= 1'b0;
         r_w_got    <= 1'b0;
         r_aw_addr  <= '0;
         r_w_data   <= '0;
         r_w_strb   <= '0;
         r_wcnt     <= '0;
         r_aw_ready <= 1'b0;
         r_w_ready  <= 1'b0;
         r_b_valid  <= 1'b0;
         r_b_resp   <= 2'b00;
      end else begin
         unique case (r_wst)
            W_IDLE: begin
               if (w_aw_hs) begin
                  r_aw_got  <= 1'b1;
                  r_aw_addr <= i_aw_addr;
               end
               if (w_w_hs) begin
                  r_w_got  <= 1'b1;
                  r_w_data <= i_w_data;
                  r_w_strb <= i_w_strb;
               end
               r_aw_ready <= ~(r_aw_got | w_aw_hs);
               r_w_ready  <= ~(r_w_got | w_w_hs);
               if (w_wr_fire) begin
                  r_wst     <= W_RESP;
                  r_b_valid <= 1'b1;
                  r_b_resp  <= w_wr_ok ? 2'b00 : 2'b10;
               end else if (w_both) begin
                  r_wst  <= W_BUSY;
                  r_wcnt <= CW'(WR_LAT - 1);
               end
            end
            W_BUSY: begin
               if (w_wr_fire) begin
                  r_wst     <= W_RESP;
                  r_wcnt    <= '0;
                  r_b_valid <= 1'b1;
                  r_b_resp  <= w_wr_ok ? 2'b00 : 2'b10;
               end else begin
                  r_wcnt <= r_wcnt - CNT_ONE;
               end
            end
            W_RESP: begin
               if (i_b_ready) begin
                  r_wst      <= W_IDLE;
                  r_b_valid  <= 1'b0;
                  r_b_resp   <= 2'b00;
                  r_aw_got   <= 1'b0;
                  r_w_got    <= 1'b0;
                  r_aw_ready <= 1'b1;
                  r_w_ready  <= 1'b1;
               end
            end
            default: r_wst <= W_IDLE;
         endcase
      end
   end

   // Read sample uses the pre-edge array value, so a same-edge commit
   // to the same word is not visible to this read.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rst      <= R_IDLE;
         r_ar_addr  <= '0;
         r_rcnt     <= '0;
         r_ar_ready <= 1'b0;
         r_r_valid  <= 1'b0;
         r_r_resp   <= 2'b00;
         r_r_data   <= '0;
      end else begin
         unique case (r_rst)
            R_IDLE: begin
               r_ar_ready <= ~w_ar_hs;
               if (w_ar_hs) begin
                  r_ar_addr <= i_ar_addr;
               end
               if (w_rd_fire) begin
                  r_rst     <= R_RESP;
                  r_r_valid <= 1'b1;
                  r_r_resp  <= w_rd_ok ? 2'b00 : 2'b10;
                  r_r_data  <= w_rd_ok ? r_mem[w_ridx] : '0;
               end else if (w_ar_hs) begin
                  r_rst  <= R_BUSY;
                  r_rcnt <= CW'(RD_LAT - 1);
               end
            end
            R_BUSY: begin
               if (w_rd_fire) begin
                  r_rst     <= R_RESP;
                  r_rcnt    <= '0;
                  r_r_valid <= 1'b1;
                  r_r_resp  <= w_rd_ok ? 2'b00 : 2'b10;
                  r_r_data  <= w_rd_ok ? r_mem[w_ridx] : '0;
               end else begin
                  r_rcnt <= r_rcnt - CNT_ONE;
               end
            end
            R_RESP: begin
               if (i_r_ready) begin
                  r_rst      <= R_IDLE;
                  r_r_valid  <= 1'b0;
                  r_r_resp   <= 2'b00;
                  r_r_data   <= '0;
                  r_ar_ready <= 1'b1;
               end
            end
            default: r_rst <= R_IDLE;
         endcase
      end
   end

   assign o_aw_ready = r_aw_ready;
   assign o_w_ready  = r_w_ready;
   assign o_b_valid  = r_b_valid;
   assign o_b_resp   = r_b_resp;
   assign o_ar_ready = r_ar_ready;
   assign o_r_valid  = r_r_valid;
   assign o_r_resp   = r_r_resp;
   assign o_r_data   = r_r_data;

endmodule
